// File: rtl/lcd_bus_scheduler.sv
// lcd_bus_scheduler
// Two-client byte-write scheduler for an HD44780-style LCD in 4-bit mode.
// Client 0 is the CGRAM glyph loader, client 1 the screen text writer.
// Each accepted byte goes out as a high nibble then a low nibble, each with
// a timed E strobe, and is followed by a settle delay. That delay is longer
// for clear/home commands.
// A byte sent with last=0 locks the bus to its client until that client's
// last=1 byte is accepted, so multi-byte sequences never interleave.
// Optional feature: define LCD_SCHED_INIT_EN to add the power-on init
// sequence (POR wait, 3/3/3/2 nibbles, then 0x28 0x0C 0x06 0x01).
module lcd_bus_scheduler #(
  parameter int unsigned E_HIGH_CYC     = 20,
  parameter int unsigned NIBBLE_GAP_CYC = 20,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLR_WAIT_CYC   = 82000,
  parameter int unsigned POR_WAIT_CYC   = 750000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  last,
  input  logic [1:0]  req_rs,
  input  logic [15:0] req_data,
  output logic [1:0]  ack,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e,
  output logic [3:0]  lcd_data
);

  localparam int unsigned CNT_MAX = 1048575;

  // Every delay must fit the 20-bit phase counter and be at least one cycle.
  if (E_HIGH_CYC < 1 || E_HIGH_CYC > CNT_MAX ||
      NIBBLE_GAP_CYC < 1 || NIBBLE_GAP_CYC > CNT_MAX ||
      CMD_WAIT_CYC < 1 || CMD_WAIT_CYC > CNT_MAX ||
      CLR_WAIT_CYC < 1 || CLR_WAIT_CYC > CNT_MAX ||
      POR_WAIT_CYC < 1 || POR_WAIT_CYC > CNT_MAX) begin : g_param_check
    $error("lcd_bus_scheduler: timing parameters must lie in 1..1048575");
  end

  // The counter runs from 0 while a timed phase is active. A phase ends on
  // the cycle the count equals its length minus one.
  localparam logic [19:0] E_LAST   = 20'(E_HIGH_CYC - 1);
  localparam logic [19:0] GAP_LAST = 20'(NIBBLE_GAP_CYC - 1);
  localparam logic [19:0] CMD_LAST = 20'(CMD_WAIT_CYC - 1);
  localparam logic [19:0] CLR_LAST = 20'(CLR_WAIT_CYC - 1);
`ifdef LCD_SCHED_INIT_EN
  localparam logic [19:0] POR_LAST = 20'(POR_WAIT_CYC - 1);
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_HI_E,
    S_HI_GAP,
    S_LO_SET,
    S_LO_E,
    S_SETTLE
`ifdef LCD_SCHED_INIT_EN
    , S_INIT_POR,
    S_INIT_SET,
    S_INIT_E,
    S_INIT_WAIT
`endif
  } state_e;

`ifdef LCD_SCHED_INIT_EN
  localparam state_e RESET_STATE = S_INIT_POR;
`else
  localparam state_e RESET_STATE = S_IDLE;
`endif

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        lock_q, lock_d;
  logic        owner_q, owner_d;
  logic        ptr_q, ptr_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  grant_q, grant_d;
  logic        lcd_e_q, lcd_e_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic [3:0]  lcd_data_q, lcd_data_d;
`ifdef LCD_SCHED_INIT_EN
  logic        init_q, init_d;
  logic [1:0]  init_idx_q, init_idx_d;
`endif

  logic        win_valid;
  logic        winner;
  logic        load_go;
  logic        load_rs;
  logic [7:0]  load_byte;
  logic        is_clr;
  logic [19:0] settle_last;

  function automatic logic [1:0] onehot(input logic c);
    return c ? 2'b10 : 2'b01;
  endfunction

`ifdef LCD_SCHED_INIT_EN
  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction
`endif

  // Clear (0x01) and return-home (0x02/0x03) need the long settle time.
  assign is_clr      = !lcd_rs_q && (byte_q[7:2] == 6'd0);
  assign settle_last = is_clr ? CLR_LAST : CMD_LAST;

  // Next-state, arbitration and pin values for the following cycle.
  always_comb begin
    // NOTE: every signal is given a default first so no path through the case can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q + 20'd1;
    byte_d     = byte_q;
    lock_d     = lock_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    ack_d      = 2'b00;
    grant_d    = grant_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_data_d = lcd_data_q;
    win_valid  = 1'b0;
    winner     = 1'b0;
    load_go    = 1'b0;
    load_rs    = 1'b0;
    load_byte  = 8'h00;
`ifdef LCD_SCHED_INIT_EN
    init_d     = init_q;
    init_idx_d = init_idx_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = 20'd0;
        // A locked owner is the only candidate, even while its req is low.
        if (lock_q) begin
          winner    = owner_q;
          win_valid = req[owner_q];
        end else if (req[ptr_q]) begin
          winner    = ptr_q;
          win_valid = 1'b1;
        end else if (req[~ptr_q]) begin
          winner    = ~ptr_q;
          win_valid = 1'b1;
        end
        if (win_valid) begin
          load_go        = 1'b1;
          load_rs        = req_rs[winner];
          load_byte      = winner ? req_data[15:8] : req_data[7:0];
          ack_d[winner]  = 1'b1;
          grant_d        = onehot(winner);
          if (last[winner]) begin
            lock_d = 1'b0;
            ptr_d  = ~winner;
          end else begin
            lock_d  = 1'b1;
            owner_d = winner;
          end
        end
      end

      S_LOAD: begin
        cnt_d   = 20'd0;
        state_d = S_HI_E;
      end

      S_HI_E: begin
        if (cnt_q == E_LAST) begin
          cnt_d   = 20'd0;
          state_d = S_HI_GAP;
        end
      end

      S_HI_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d      = 20'd0;
          state_d    = S_LO_SET;
          lcd_data_d = byte_q[3:0];
        end
      end

      S_LO_SET: begin
        cnt_d   = 20'd0;
        state_d = S_LO_E;
      end

      S_LO_E: begin
        if (cnt_q == E_LAST) begin
          cnt_d   = 20'd0;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == settle_last) begin
          cnt_d = 20'd0;
`ifdef LCD_SCHED_INIT_EN
          if (init_q) begin
            if (init_idx_q == 2'd3) begin
              init_d     = 1'b0;
              init_idx_d = 2'd0;
              state_d    = S_IDLE;
            end else begin
              init_idx_d = init_idx_q + 2'd1;
              load_go    = 1'b1;
              load_byte  = init_byte(init_idx_q + 2'd1);
            end
          end else
`endif
          begin
            state_d = S_IDLE;
            grant_d = lock_q ? onehot(owner_q) : 2'b00;
          end
        end
      end

`ifdef LCD_SCHED_INIT_EN
      S_INIT_POR: begin
        if (cnt_q == POR_LAST) begin
          cnt_d      = 20'd0;
          state_d    = S_INIT_SET;
          lcd_rs_d   = 1'b0;
          lcd_data_d = init_nibble(init_idx_q);
        end
      end

      S_INIT_SET: begin
        cnt_d   = 20'd0;
        state_d = S_INIT_E;
      end

      S_INIT_E: begin
        if (cnt_q == E_LAST) begin
          cnt_d   = 20'd0;
          state_d = S_INIT_WAIT;
        end
      end

      S_INIT_WAIT: begin
        if (cnt_q == CLR_LAST) begin
          cnt_d = 20'd0;
          if (init_idx_q == 2'd3) begin
            // Nibble phase done; the four setup bytes use the normal path.
            init_d     = 1'b1;
            init_idx_d = 2'd0;
            load_go    = 1'b1;
            load_byte  = init_byte(2'd0);
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            state_d    = S_INIT_SET;
            lcd_data_d = init_nibble(init_idx_q + 2'd1);
          end
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        cnt_d   = 20'd0;
      end
    endcase

    // Any byte acceptance (client or init) latches it and shows the high nibble.
    if (load_go) begin
      state_d    = S_LOAD;
      cnt_d      = 20'd0;
      byte_d     = load_byte;
      lcd_rs_d   = load_rs;
      lcd_data_d = load_byte[7:4];
    end

    // E is registered from the next state so the pin never glitches.
    lcd_e_d = (state_d == S_HI_E) || (state_d == S_LO_E)
`ifdef LCD_SCHED_INIT_EN
              || (state_d == S_INIT_E)
`endif
              ;
  end

  // State and pin registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      cnt_q      <= 20'd0;
      byte_q     <= 8'h00;
      lock_q     <= 1'b0;
      owner_q    <= 1'b0;
      ptr_q      <= 1'b0;
      ack_q      <= 2'b00;
      grant_q    <= 2'b00;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 4'h0;
`ifdef LCD_SCHED_INIT_EN
      init_q     <= 1'b0;
      init_idx_q <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      ack_q      <= ack_d;
      grant_q    <= grant_d;
      lcd_e_q    <= lcd_e_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_data_q <= lcd_data_d;
`ifdef LCD_SCHED_INIT_EN
      init_q     <= init_d;
      init_idx_q <= init_idx_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign grant    = grant_q;
  assign busy     = (state_q != S_IDLE);
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = lcd_e_q;
  assign lcd_data = lcd_data_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// tb_lcd_bus_scheduler
// Self-checking bench for lcd_bus_scheduler using shortened timing
// parameters. Expected behaviour comes from a transaction-level model: whole
// bursts are served alternately, and each byte's pin waveform is derived
// from the phase lengths.
module tb_lcd_bus_scheduler;

  localparam int E   = 3;
  localparam int G   = 2;
  localparam int CMD = 5;
  localparam int CLR = 9;
  localparam int POR = 4;
`ifdef LCD_SCHED_INIT_EN
  localparam logic INIT_EN = 1'b1;
`else
  localparam logic INIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  last;
  logic [1:0]  req_rs;
  logic [15:0] req_data;
  logic [1:0]  ack;
  logic [1:0]  grant;
  logic        busy;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_e;
  logic [3:0]  lcd_data;

  lcd_bus_scheduler #(
    .E_HIGH_CYC    (E),
    .NIBBLE_GAP_CYC(G),
    .CMD_WAIT_CYC  (CMD),
    .CLR_WAIT_CYC  (CLR),
    .POR_WAIT_CYC  (POR)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .last    (last),
    .req_rs  (req_rs),
    .req_data(req_data),
    .ack     (ack),
    .grant   (grant),
    .busy    (busy),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_e   (lcd_e),
    .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic       c;
    logic       rs;
    logic [7:0] data;
    logic       last;
  } byte_t;

  typedef struct packed {
    logic       c;
    logic       rs;
    logic [7:0] data;
    logic [3:0] hi;
    logic [3:0] lo;
    logic [7:0] occ;
  } vec_t;

  byte_t cq0[$];
  byte_t cq1[$];
  byte_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [1:0] onehot(input logic c);
    return c ? 2'b10 : 2'b01;
  endfunction

  // Cycles from LOAD to IDLE: load, E, gap, low setup, E, settle.
  function automatic int occ_of(input logic rs, input logic [7:0] d);
    return 2 + 2 * E + G + ((!rs && d < 8'd4) ? CLR : CMD);
  endfunction

  // Drive each client's head-of-queue byte, or drop req if it has none.
  task automatic present();
    if (cq0.size() > 0) begin
      req[0] = 1'b1; last[0] = cq0[0].last; req_rs[0] = cq0[0].rs; req_data[7:0] = cq0[0].data;
    end else begin
      req[0] = 1'b0;
    end
    if (cq1.size() > 0) begin
      req[1] = 1'b1; last[1] = cq1[0].last; req_rs[1] = cq1[0].rs; req_data[15:8] = cq1[0].data;
    end else begin
      req[1] = 1'b0;
    end
  endtask

  task automatic advance(input logic c);
    if (c) begin
      if (cq1.size() > 0) void'(cq1.pop_front());
    end else begin
      if (cq0.size() > 0) void'(cq0.pop_front());
    end
    present();
  endtask

  task automatic release_reset();
`ifdef LCD_SCHED_INIT_EN
    logic [3:0] init_exp [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
    logic [3:0] nibs[$];
    logic       prev_e = 1'b0;
    logic       ack_seen = 1'b0;
    int         n = 0;
`endif
    rst_n = 1'b1;
`ifdef LCD_SCHED_INIT_EN
    do begin
      @(negedge clk);
      n++;
      if (lcd_e && !prev_e) nibs.push_back(lcd_data);
      prev_e = lcd_e;
      if (ack != 2'b00) ack_seen = 1'b1;
    end while (busy && n < 5000);
    check("init_done", 32'(busy), 32'(0));
    check("init_no_ack", 32'(ack_seen), 32'(0));
    check("init_nibble_count", 32'(nibs.size()), 32'(12));
    for (int i = 0; i < 12 && i < nibs.size(); i++)
      check($sformatf("init_nibble_%0d", i), 32'(nibs[i]), 32'(init_exp[i]));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    cq0.delete();
    cq1.delete();
    repeat (3) @(negedge clk);
    check("rst_pins", 32'({ack, grant, busy, lcd_e, lcd_rs, lcd_rw, lcd_data}),
          32'({2'b00, 2'b00, INIT_EN, 1'b0, 1'b0, 1'b0, 4'h0}));
    release_reset();
  endtask

  // Wait for one byte's ack, then follow its whole waveform to IDLE.
  task automatic serve_check(input logic c, input logic rs, input logic [3:0] hi,
                             input logic [3:0] lo, input logic lst, input int occ,
                             input int max_wait, output int waited);
    int         bad = 0;
    int         first_t = -1;
    logic       exp_e;
    logic [3:0] exp_d;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (ack == 2'b00 && waited < max_wait);
    check($sformatf("ack_client%0d", c), 32'(ack), 32'(onehot(c)));
    if (ack == 2'b00) return;
    check("load_grant", 32'(grant), 32'(onehot(c)));
    check("load_pins", 32'({busy, lcd_e, lcd_rw, lcd_rs, lcd_data}), 32'({1'b1, 1'b0, 1'b0, rs, hi}));
    advance(ack[1]);
    for (int t = 1; t < occ; t++) begin
      @(negedge clk);
      exp_e = (t <= E) || ((t >= E + G + 2) && (t <= 2 * E + G + 1));
      exp_d = (t <= E + G) ? hi : lo;
      if ({lcd_e, lcd_data, lcd_rs, busy, grant, ack} !== {exp_e, exp_d, rs, 1'b1, onehot(c), 2'b00}) begin
        if (bad == 0) first_t = t;
        bad++;
      end
    end
    check($sformatf("wave_client%0d_first_bad_t%0d", c, first_t), 32'(bad), 32'(0));
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_grant", 32'(grant), 32'(lst ? 2'b00 : onehot(c)));
    check("idle_hold", 32'({lcd_e, lcd_rs, lcd_data}), 32'({1'b0, rs, lo}));
  endtask

  task automatic serve_model(input byte_t b, input int max_wait);
    int w;
    serve_check(b.c, b.rs, b.data[7:4], b.data[3:0], b.last, occ_of(b.rs, b.data), max_wait, w);
  endtask

  task automatic push(input byte_t b);
    if (b.c) cq1.push_back(b);
    else cq0.push_back(b);
  endtask

  // Reference order with both clients requesting continuously: whole bursts
  // alternate, starting with client 0; an empty client is skipped.
  task automatic build_expected();
    byte_t m0[$] = cq0;
    byte_t m1[$] = cq1;
    byte_t b;
    logic  ptr = 1'b0;
    logic  c;
    exp_q.delete();
    while (m0.size() + m1.size() > 0) begin
      if (ptr) c = (m1.size() > 0) ? 1'b1 : 1'b0;
      else     c = (m0.size() > 0) ? 1'b0 : 1'b1;
      do begin
        b = c ? m1.pop_front() : m0.pop_front();
        exp_q.push_back(b);
      end while (!b.last);
      ptr = !c;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t  vecs [8];
    int    waited;
    logic  any_ack;
    byte_t b;

    vecs[0] = '{1'b0, 1'b1, 8'hA5, 4'hA, 4'h5, 8'd15};
    vecs[1] = '{1'b1, 1'b0, 8'h01, 4'h0, 4'h1, 8'd19};
    vecs[2] = '{1'b0, 1'b0, 8'h02, 4'h0, 4'h2, 8'd19};
    vecs[3] = '{1'b1, 1'b0, 8'h03, 4'h0, 4'h3, 8'd19};
    vecs[4] = '{1'b0, 1'b0, 8'h04, 4'h0, 4'h4, 8'd15};
    vecs[5] = '{1'b1, 1'b1, 8'h01, 4'h0, 4'h1, 8'd15};
    vecs[6] = '{1'b0, 1'b0, 8'h80, 4'h8, 4'h0, 8'd15};
    vecs[7] = '{1'b1, 1'b1, 8'hFF, 4'hF, 4'hF, 8'd15};

    rst_n = 1'b0; req = 2'b00; last = 2'b00; req_rs = 2'b00; req_data = 16'h0000;
    do_reset();

    // Single-byte transactions from the vector table.
    for (int i = 0; i < 8; i++) begin
      push('{vecs[i].c, vecs[i].rs, vecs[i].data, 1'b1});
      present();
      serve_check(vecs[i].c, vecs[i].rs, vecs[i].hi, vecs[i].lo, 1'b1, int'(vecs[i].occ), 5, waited);
      check($sformatf("ack_latency_vec%0d", i), 32'(waited), 32'(1));
    end

    // Simultaneous requests: pointer alternates over four single-byte bursts.
    do_reset();
    push('{1'b0, 1'b1, 8'h11, 1'b1});
    push('{1'b0, 1'b1, 8'h33, 1'b1});
    push('{1'b1, 1'b1, 8'h22, 1'b1});
    push('{1'b1, 1'b1, 8'h44, 1'b1});
    present();
    serve_model('{1'b0, 1'b1, 8'h11, 1'b1}, 5);
    serve_model('{1'b1, 1'b1, 8'h22, 1'b1}, 5);
    serve_model('{1'b0, 1'b1, 8'h33, 1'b1}, 5);
    serve_model('{1'b1, 1'b1, 8'h44, 1'b1}, 5);

    // Nine-byte CGRAM burst from client 0 while client 1 keeps requesting.
    do_reset();
    push('{1'b0, 1'b0, 8'h40, 1'b0});
    for (int k = 0; k < 8; k++) push('{1'b0, 1'b1, 8'h1F, (k == 7)});
    push('{1'b1, 1'b1, 8'h55, 1'b1});
    present();
    serve_model('{1'b0, 1'b0, 8'h40, 1'b0}, 5);
    for (int k = 0; k < 8; k++) serve_model('{1'b0, 1'b1, 8'h1F, (k == 7)}, 5);
    serve_model('{1'b1, 1'b1, 8'h55, 1'b1}, 5);

    // Lock owner goes quiet in IDLE: the other client must not be served.
    do_reset();
    push('{1'b0, 1'b1, 8'h30, 1'b0});
    push('{1'b1, 1'b1, 8'h41, 1'b1});
    present();
    serve_model('{1'b0, 1'b1, 8'h30, 1'b0}, 5);
    any_ack = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ack != 2'b00) any_ack = 1'b1;
    end
    check("lock_wait_no_ack", 32'(any_ack), 32'(0));
    check("lock_wait_grant", 32'(grant), 32'(2'b01));
    push('{1'b0, 1'b1, 8'h31, 1'b1});
    present();
    serve_model('{1'b0, 1'b1, 8'h31, 1'b1}, 5);
    serve_model('{1'b1, 1'b1, 8'h41, 1'b1}, 5);

    // Reset during the first E pulse of a locking byte.
    do_reset();
    push('{1'b1, 1'b1, 8'h5A, 1'b0});
    present();
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (ack == 2'b00 && waited < 5);
    check("mid_ack", 32'(ack), 32'(2'b10));
    advance(1'b1);
    repeat (2) @(negedge clk);
    check("mid_e_high", 32'(lcd_e), 32'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_pins", 32'({ack, grant, busy, lcd_e, lcd_rs, lcd_data}),
          32'({2'b00, 2'b00, INIT_EN, 1'b0, 1'b0, 4'h0}));
    any_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ack != 2'b00) any_ack = 1'b1;
    end
    check("mid_rst_no_ack", 32'(any_ack), 32'(0));
    release_reset();
    push('{1'b0, 1'b0, 8'h33, 1'b1});
    present();
    serve_model('{1'b0, 1'b0, 8'h33, 1'b1}, 5);

    // Randomized bursts from both clients against the reference order.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 2; c++) begin
        int nb = $urandom_range(0, 3);
        for (int j = 0; j < nb; j++) begin
          int len = $urandom_range(1, 3);
          for (int k = 0; k < len; k++) begin
            b.c    = 1'(c);
            b.rs   = 1'($urandom_range(0, 1));
            b.data = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            b.last = (k == len - 1);
            push(b);
          end
        end
      end
      if (cq0.size() + cq1.size() == 0) push('{1'b0, 1'b1, 8'h7E, 1'b1});
      build_expected();
      present();
      foreach (exp_q[i]) serve_model(exp_q[i], 40);
      any_ack = 1'b0;
      repeat (30) begin
        @(negedge clk);
        if (ack != 2'b00) any_ack = 1'b1;
      end
      check($sformatf("rand%0d_tail_no_ack", r), 32'(any_ack), 32'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
